// File: rtl/sha_mem_responder_if.sv
// Engine memory port and host access port of the SHA memory responder.
// master = engine/host side, slave = responder side.
interface sha_mem_responder_if;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        engine_start;
    logic        engine_done;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        host_go;

    modport master (
        output mem_addr, mem_we, mem_wdata, engine_done,
        output host_valid, host_we, host_addr, host_wdata, host_go,
        input  mem_rdata, engine_start, host_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  mem_addr, mem_we, mem_wdata, engine_done,
        input  host_valid, host_we, host_addr, host_wdata, host_go,
        output mem_rdata, engine_start, host_ready, host_rvalid, host_rdata
    );
endinterface

// File: rtl/sha_mem_responder.sv
// Word memory shared between a host (preload/readback, IDLE only) and the
// SHA-256 engine (ARM/RUN only), with a run FSM, timeout and sticky error.
module sha_mem_responder #(
    parameter int          DEPTH          = 256,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [31:0] OOR_DATA       = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    sha_mem_responder_if.slave    bus,
    output logic                  busy,
    output logic                  error,
    output logic [3:0]            hash_wr_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] ARM   = 2'd2;
    localparam logic [1:0] RUN   = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    logic [31:0]   mem [DEPTH];

    logic          eng_act, eng_in_rng, host_acc, host_in_rng, go_acc;
    logic [AW-1:0] eng_idx, host_idx;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;

    assign eng_act     = (state == ARM) || (state == RUN);
    assign host_acc    = bus.host_valid && bus.host_ready;
    assign go_acc      = (state == IDLE) && bus.host_go;
    assign eng_in_rng  = {16'd0, bus.mem_addr} < 32'(DEPTH);
    assign host_in_rng = {16'd0, bus.host_addr} < 32'(DEPTH);
    assign eng_idx     = bus.mem_addr[AW-1:0];
    assign host_idx    = bus.host_addr[AW-1:0];

    assign bus.engine_start = (state == START);
    assign bus.host_ready   = (state == IDLE) && !rst;
    assign busy             = (state != IDLE);

    // Timeout also applies in ARM so an engine that never drops done cannot
    // hold the array forever.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:  if (bus.host_go) state_nxt = START;
            START: state_nxt = ARM;
            ARM: begin
                if (!bus.engine_done) begin
                    state_nxt = RUN;
                end else if (timer == TIMER_LAST) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            RUN: begin
                if (bus.engine_done) begin
                    state_nxt = IDLE;
                end else if (timer == TIMER_LAST) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            error         <= 1'b0;
            hash_wr_count <= '0;
        end else begin
            state <= state_nxt;
            timer <= (state == IDLE) ? '0 : timer + 1'b1;

            // A go clears the previous run's error unless the same-cycle host access is itself out of range.
            if (go_acc)
                error <= host_acc && !host_in_rng;
            else if (timeout_hit || (eng_act && !eng_in_rng) || (host_acc && !host_in_rng))
                error <= 1'b1;

            if (go_acc)
                hash_wr_count <= '0;
            else if (eng_act && bus.mem_we && hash_wr_count != 4'hF)
                hash_wr_count <= hash_wr_count + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rdata   <= '0;
            bus.host_rdata  <= '0;
            bus.host_rvalid <= 1'b0;
        end else begin
            bus.host_rvalid <= host_acc && !bus.host_we;
            if (host_acc && !bus.host_we)
                bus.host_rdata <= host_in_rng ? mem[host_idx] : OOR_DATA;
            if (eng_act)
                bus.mem_rdata <= eng_in_rng ? mem[eng_idx] : OOR_DATA;
        end
    end

    // Host and engine own the array in disjoint states, so one write port suffices.
    assign wr_en   = (host_acc && bus.host_we && host_in_rng) ||
                     (eng_act && bus.mem_we && eng_in_rng);
    assign wr_idx  = eng_act ? eng_idx : host_idx;
    assign wr_data = eng_act ? bus.mem_wdata : bus.host_wdata;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end
endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
Memory-side responder for the SHA-256 engine's word-addressed memory interface. It serves the engine's read and write requests from an internal word array with 1-cycle registered read latency. It also gives a host port exclusive access to the array to preload message words and read back the 8 hash words. A small run FSM starts the engine, hands it the array, watches done, applies a timeout, and returns ownership to the host.

Parameters:
DEPTH, 256, number of 32-bit words in the array; addresses >= DEPTH are out of range
TIMEOUT_CYCLES, 4096, maximum cycles in RUN before the run is aborted
OOR_DATA, 32'hDEADBEEF, read data returned for out-of-range reads

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
mem_addr  in  16  engine word address
mem_we  in  1  engine write enable
mem_wdata  in  32  engine write data
mem_rdata  out  32  engine read data, registered, valid 1 cycle after mem_addr
engine_start  out  1  one-cycle start pulse to the engine
engine_done  in  1  engine done level; high whenever the engine is idle
host_valid  in  1  host request valid
host_ready  out  1  host may issue a request (high only in IDLE)
host_we  in  1  1 = write, 0 = read
host_addr  in  16  host word address
host_wdata  in  32  host write data
host_rvalid  out  1  1-cycle pulse; host_rdata valid
host_rdata  out  32  host read data
host_go  in  1  request an engine run (sampled in IDLE only)
busy  out  1  high in every state except IDLE
error  out  1  sticky: out-of-range access or timeout
hash_wr_count  out  4  engine writes in the current run, saturates at 15

Behaviour:
- Reset (async, active-high): state=IDLE. mem_rdata, host_rdata, host_rvalid, engine_start, busy, error, hash_wr_count and the timeout counter all go to 0. Array contents are not reset. host_ready = (state==IDLE) && !rst.
- States: IDLE, START, ARM, RUN.
  - IDLE: host owns the array. host_go -> START. Clears error and hash_wr_count.
  - START: engine_start=1 for exactly one cycle -> ARM.
  - ARM: wait for engine_done==0, then -> RUN. This skips the done level the engine holds while idle. The timeout counter runs from START.
  - RUN: engine owns the array. engine_done==1 -> IDLE. Counter reaching TIMEOUT_CYCLES-1 -> set error, -> IDLE.
- Host access is honoured only when host_valid && host_ready.
  - Write: mem[host_addr] <= host_wdata.
  - Read: host_rdata <= mem[host_addr] and host_rvalid=1 on the next cycle.
- host_go and host_valid in the same IDLE cycle: both are accepted. The access completes; the FSM enters START next cycle.
- Engine port is active in ARM and RUN only.
  - mem_rdata <= mem[mem_addr] every cycle in those states; it holds its value otherwise.
  - mem_we writes mem[mem_addr] <= mem_wdata and increments hash_wr_count (saturating at 15).
- Same-cycle write and read to the same address return the old data (read-before-write).
- Out-of-range address (>= DEPTH) from either port:
  - Write is dropped.
  - Read returns OOR_DATA.
  - error is set (sticky until the next accepted host_go or reset).
- Engine requests in IDLE/START are ignored: no write, no count. Host requests outside IDLE are ignored because host_ready=0.
- Reset mid-run aborts immediately to IDLE. Array contents are retained.
- busy=1 in START, ARM and RUN.

Test Plan:
- Reset then host write mem[0..3]=32'h00000001..4, then read addr 2 -> host_rvalid one cycle after acceptance, host_rdata=32'h00000003; host_ready=1 throughout.
- host_go in IDLE with engine_done=1 -> engine_start high exactly 1 cycle. FSM holds ARM while done=1, enters RUN after done=0, busy=1 from the cycle after go.
- In RUN: engine reads addr 5 -> mem_rdata=mem[5] the next cycle. Engine writes 8 words to addr 16..23 then raises done -> IDLE, hash_wr_count=8. Host reads addr 20 returns the written value.
- Engine writes addr 300 with DEPTH=256 -> no array change, error=1. Engine read of 300 -> mem_rdata=32'hDEADBEEF. Next host_go clears error.
- engine_done held low after start for TIMEOUT_CYCLES=16 -> error=1, return to IDLE, host_ready=1. Host_valid during RUN -> no host_rvalid.
- rst pulse mid-RUN -> busy=0, engine_start=0, hash_wr_count=0 asynchronously. Data preloaded before the run still reads back unchanged.
